// File: rtl/commit_trace_fifo_if.sv
// rtl/commit_trace_fifo_if.sv - capture and drain stream bundle for commit_trace_fifo
//
// Signals:
//   capture_en        record the current core outputs this cycle
//   core_address      PC of the executing instruction
//   core_instruction  instruction word
//   core_result       write-back value
//   out_valid         head record available
//   out_ready         sink accepts head record
//   out_pc / out_instr / out_result  head record fields
// Modports:
//   master  drives the core outputs and the sink's ready (core + sink side)
//   slave   the trace FIFO itself
interface commit_trace_fifo_if;
    logic        capture_en;
    logic [31:0] core_address;
    logic [31:0] core_instruction;
    logic [31:0] core_result;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] out_result;

    modport master (
        output capture_en, core_address, core_instruction, core_result, out_ready,
        input  out_valid, out_pc, out_instr, out_result
    );

    modport slave (
        input  capture_en, core_address, core_instruction, core_result, out_ready,
        output out_valid, out_pc, out_instr, out_result
    );
endinterface

// File: rtl/commit_trace_fifo.sv
// rtl/commit_trace_fifo.sv - retired-instruction trace FIFO with overflow accounting
//
// Buffers one {pc, instr, result} record per capture cycle and drains them over a
// valid/ready stream. Records arriving while full (with no pop) are discarded and
// counted in a saturating counter; a sticky flag marks the first loss.
//
// Optional feature: define TRACE_SKIP_NOP_EN to ignore capture requests whose
// instruction word is 32'h00000000 (neither stored nor counted as dropped).
//
// Ports:
//   clk       system clock, rising edge
//   reset     asynchronous active-low reset
//   bus       commit_trace_fifo_if.slave: capture inputs and output stream
//   count     entries currently stored (registered)
//   full      count == DEPTH (registered)
//   empty     count == 0 (registered)
//   dropped   saturating count of records lost to overflow
//   overflow  sticky, set on first drop
module commit_trace_fifo #(
    parameter int DEPTH  = 16,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    commit_trace_fifo_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [DROP_W-1:0]        dropped,
    output logic                     overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [95:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [95:0]   head;
    logic          push_req;
    logic          pop;
    logic          push;
    logic [CW-1:0] count_next;

    always_comb begin
        push_req = bus.capture_en;
`ifdef TRACE_SKIP_NOP_EN
        if (bus.core_instruction == 32'h0000_0000) begin
            push_req = 1'b0;
        end
`endif
    end

    // A pop frees the slot at the same edge, so a full FIFO still accepts a push.
    assign pop  = !empty && bus.out_ready;
    assign push = push_req && (!full || pop);

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CW'(1);
        end else if (!push && pop) begin
            count_next = count - CW'(1);
        end
    end

    // Storage carries no reset; the output gate below hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.core_address, bus.core_instruction, bus.core_result};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            dropped  <= '0;
            overflow <= 1'b0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap to 0.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
            if (push_req && !push) begin
                overflow <= 1'b1;
                if (dropped != '1) begin
                    dropped <= dropped + DROP_W'(1);
                end
            end
        end
    end

    // Gating on empty forces zeros during reset and after it, before any push.
    assign head           = mem[rd_ptr];
    assign bus.out_valid  = !empty;
    assign bus.out_pc     = empty ? 32'h0 : head[95:64];
    assign bus.out_instr  = empty ? 32'h0 : head[63:32];
    assign bus.out_result = empty ? 32'h0 : head[31:0];
endmodule
